// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone-to-stream bridge: register map, field
// positions, FIFO depth default and the register request decoder.
package wb_bridge_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned CNT_W         = 5;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;

    localparam int unsigned ST_TX_COUNT_LSB = 0;
    localparam int unsigned ST_RX_COUNT_LSB = 8;
    localparam int unsigned ST_TX_OVF       = 16;
    localparam int unsigned ST_RX_UDF       = 17;

    localparam int unsigned CTRL_IRQ_EN = 0;
    localparam int unsigned CTRL_FLUSH  = 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_e;

    // One-hot view of which register access a bus request performs
    typedef struct packed {
        logic tx_wr;
        logic rx_rd;
        logic st_rd;
        logic st_wr;
        logic ctrl_rd;
        logic ctrl_wr;
    } reg_req_t;

    // Wrong-direction accesses (TXDATA read, RXDATA write) decode to nothing
    function automatic reg_req_t decode_req(input logic [7:0] off, input logic we);
        reg_req_t r;
        r = '0;
        case (off)
            OFF_TXDATA: r.tx_wr = we;
            OFF_RXDATA: r.rx_rd = !we;
            OFF_STATUS: begin
                r.st_rd = !we;
                r.st_wr = we;
            end
            OFF_CTRL: begin
                r.ctrl_rd = !we;
                r.ctrl_wr = we;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] status_word(
        input logic [CNT_W-1:0] tx_count,
        input logic [CNT_W-1:0] rx_count,
        input logic             tx_ovf,
        input logic             rx_udf
    );
        logic [DATA_W-1:0] w;
        w = '0;
        w[ST_TX_COUNT_LSB +: CNT_W] = tx_count;
        w[ST_RX_COUNT_LSB +: CNT_W] = rx_count;
        w[ST_TX_OVF]                = tx_ovf;
        w[ST_RX_UDF]                = rx_udf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; flush overrides push and pop.
// Head reads 0 while empty so downstream data stays quiet.
module sync_fifo
    import wb_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = empty ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_stream_bridge.sv
// Wishbone classic slave exposing a TX stream FIFO, an RX stream FIFO,
// sticky status flags and an interrupt with a one-wait-state handshake.
module wb_stream_bridge
    import wb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    bus_state_e state_q, state_d;
    logic       start;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // start marks the IDLE->ACK edge, the only point where side effects occur
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    state_d = S_ACK;
                    start   = 1'b1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic     hit;
    reg_req_t req;

    assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req = (start && hit) ? decode_req(wbs_adr_i[7:0], wbs_we_i) : '0;

    logic [DATA_W-1:0] tx_head, rx_head;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_pop, rx_push;
    logic              ctrl_wr_en, flush, sticky_clr;
    logic              tx_ovf_q, rx_udf_q, irq_en_q;

    assign ctrl_wr_en = req.ctrl_wr & wbs_sel_i[0];
    assign flush      = ctrl_wr_en & wbs_dat_i[CTRL_FLUSH];
    assign sticky_clr = req.st_wr & wbs_sel_i[2];
    assign tx_pop     = ~tx_empty & tx_ready_i;
    assign rx_push    = rx_valid_i & ~rx_full;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (req.tx_wr),
        .push_data (wbs_dat_i),
        .pop       (tx_pop),
        .flush     (flush),
        .head      (tx_head),
        .count     (tx_count),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (rx_push),
        .push_data (rx_data_i),
        .pop       (req.rx_rd),
        .flush     (flush),
        .head      (rx_head),
        .count     (rx_count),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_head;
    assign rx_ready_o = ~rx_full;

    logic [DATA_W-1:0] rdata;

    // Read data is nonzero only for a decoded read; the RX head is 0 when empty
    always_comb begin
        rdata = '0;
        if (req.rx_rd)        rdata = rx_head;
        else if (req.st_rd)   rdata = status_word(tx_count, rx_count, tx_ovf_q, rx_udf_q);
        else if (req.ctrl_rd) rdata = DATA_W'(irq_en_q);
    end

    // Sticky set terms come first so a same-cycle event beats a W1C clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            wbs_ack_o <= start;
            wbs_dat_o <= rdata;
            tx_ovf_q  <= (req.tx_wr & tx_full)
                       | (tx_ovf_q & ~(sticky_clr & wbs_dat_i[ST_TX_OVF]));
            rx_udf_q  <= (req.rx_rd & rx_empty)
                       | (rx_udf_q & ~(sticky_clr & wbs_dat_i[ST_RX_UDF]));
            if (ctrl_wr_en) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
            irq_o     <= irq_en_q & ((rx_count != '0) | tx_ovf_q | rx_udf_q);
        end
    end

    logic unused_sel;
    assign unused_sel = ^{wbs_sel_i[3], wbs_sel_i[1]};

endmodule
